// File: rtl/leading_zeros_pkg.sv
// Shared constants and state encoding for the leading-zero counter and
// its inverse, the sequential denormalizer.
package leading_zeros_pkg;

  localparam int unsigned LZ_WIDTH = 8;
  localparam int unsigned LZ_CW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lz_state_e;

endpackage : leading_zeros_pkg

// File: rtl/leading_zeros_restore.sv
// Sequential denormalizer: rebuilds in_mant >> in_zeros one bit per clock,
// flagging pairs that are not a legal normalized encoding.
module leading_zeros_restore
  import leading_zeros_pkg::*;
#(
  parameter int unsigned WIDTH = LZ_WIDTH,
  parameter int unsigned CW    = LZ_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [CW-1:0]    in_zeros,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic             out_err
);

  localparam logic [CW-1:0] ZMAX = CW'(WIDTH);

  lz_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [CW-1:0]    zeros_sat_c;
  logic             illegal_c;

  // Saturated shift count and legality of the offered pair
  always_comb begin
    zeros_sat_c = (in_zeros > ZMAX) ? ZMAX : in_zeros;
    illegal_c   = (in_zeros > ZMAX)
               || ((in_zeros < ZMAX) && !in_mant[WIDTH-1])
               || ((in_zeros == ZMAX) && (in_mant != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_mant;
          cnt_d   = zeros_sat_c;
          err_d   = illegal_c;
          state_d = (zeros_sat_c != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decode straight from state; data comes from registers
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_num   = shreg_q;
  assign out_err   = err_q;

endmodule : leading_zeros_restore

// File: tb/tb_leading_zeros_restore.sv
// Directed bench for leading_zeros_restore: hand-computed results, latency,
// backpressure hold and asynchronous reset abort.
module tb_leading_zeros_restore;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mant;
  logic [3:0] in_zeros;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_num;
  logic       out_err;

  int vectors = 0;
  int miscompares = 0;

  leading_zeros_restore #(.WIDTH(8), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_zeros  (in_zeros),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offer one pair, count edges (accept edge = 1) until out_valid, check result
  task automatic run_txn(input string tag, input logic [7:0] mant, input logic [3:0] zeros,
                         input logic [7:0] exp_num, input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mant  = mant;
    in_zeros = zeros;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_num"}, 32'(out_num), 32'(exp_num));
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_ret_idle"}, 32'(in_ready), 32'd1);
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_zeros  = '0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_num",   32'(out_num),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Legal encodings
    run_txn("z2",    8'b1001_0000, 4'd2, 8'b0010_0100, 1'b0, 3);
    run_txn("z0",    8'b1010_0101, 4'd0, 8'b1010_0101, 1'b0, 1);
    run_txn("z8",    8'b0000_0000, 4'd8, 8'b0000_0000, 1'b0, 9);
    run_txn("z7",    8'b1000_0000, 4'd7, 8'b0000_0001, 1'b0, 8);

    // Illegal encodings
    run_txn("msb0",  8'b0100_0000, 4'd1, 8'b0010_0000, 1'b1, 2);
    run_txn("z9",    8'b1011_0110, 4'd9, 8'b0000_0000, 1'b1, 9);
    run_txn("z8nz",  8'b1000_0000, 4'd8, 8'b0000_0000, 1'b1, 9);

    // Backpressure: hold DONE for 5 cycles, ignore an in_valid pulse
    out_ready = 1'b0;
    run_txn("bp", 8'b1100_0000, 4'd3, 8'b0001_1000, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_valid = 1'b1;
        in_mant  = 8'b1111_1111;
        in_zeros = 4'd0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_num",   32'(out_num),   32'h18);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    @(posedge clk); #1;
    check("bp_no_queued", 32'(out_valid), 32'd0);

    // Reset during the 3rd SHIFT cycle of a 6-zero transaction
    @(negedge clk);
    in_valid = 1'b1;
    in_mant  = 8'b1000_0000;
    in_zeros = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_shifting", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_num",   32'(out_num),   32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_txn("after_rst", 8'b1111_0000, 4'd4, 8'b0000_1111, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_leading_zeros_restore
